// File: rtl/kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_pkg
// Description : Shared types and constants for the keyboard event buffer.
//               PS/2 set-2 prefix bytes, prefix-decoder state encoding and the
//               10-bit event record {brk, ext, code}.
// Revision    : 1.0 - initial release
// ============================================================================
package kbd_pkg;

    // Prefix-decoder states: which prefix bytes have been seen so far
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        E0   = 2'd1,
        F0   = 2'd2,
        E0F0 = 2'd3
    } kbd_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK = 8'hF0;  // key-release prefix

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } kbd_event_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with a registered
//               head word. o_rdata shows the oldest entry whenever o_empty=0.
// Ports       : clk      - clock
//               rst_n    - synchronous reset, active-low
//               i_push   - write i_wdata (accepted if not full, or if full
//                          and a pop is accepted in the same cycle)
//               i_pop    - consume head entry (ignored when empty)
//               i_wdata  - write data
//               o_rdata  - registered head entry
//               o_count  - occupancy
//               o_full   - count == DEPTH
//               o_empty  - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [PW-1:0]    w_rd_next;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~w_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign w_rd_next = r_rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
            // Head register: the incoming word bypasses the memory when it
            // becomes the head immediately (empty, or last entry leaving).
            // Otherwise on a pop the next stored entry is loaded; that slot is
            // never the one being written, since wr_ptr differs from rd_ptr+1
            // whenever count >= 2.
            if (w_push_ok && (w_empty || (w_pop_ok && r_count == CW'(1)))) begin
                r_head <= i_wdata;
            end else if (w_pop_ok && r_count > CW'(1)) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign o_rdata = r_head;
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_event_fifo
// Description : Keyboard event buffer. Optionally folds PS/2 set-2 E0/F0
//               prefixes into single make/break events, queues them in a FWFT
//               FIFO with sticky overflow, and keeps a raw-byte snapshot.
// Ports       : clk_in            - core clock
//               rst_in            - synchronous reset, active-low
//               scancode_in       - byte from the PS/2 receiver
//               scancode_valid_in - strobe qualifying scancode_in
//               error_in          - receiver frame error strobe
//               pop_in            - consume head entry
//               clr_overflow_in   - clear sticky overflow
//               data_out          - head entry {brk, ext, code}
//               valid_out         - FIFO non-empty
//               count_out         - occupancy
//               overflow_out      - sticky: an event was dropped
//               snapshot_out      - last raw bytes, newest in [7:0]
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int SNAP_BYTES = 4,
    parameter int DECODE     = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [7:0]                 scancode_in,
    input  logic                       scancode_valid_in,
    input  logic                       error_in,
    input  logic                       pop_in,
    input  logic                       clr_overflow_in,
    output logic [9:0]                 data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic [8*SNAP_BYTES-1:0]    snapshot_out
);

    logic       w_byte_ok;
    logic       w_emit;
    kbd_event_t w_event;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    logic       r_overflow;
    logic [8*SNAP_BYTES-1:0] r_snap;

    // A byte coinciding with a frame error is discarded everywhere
    assign w_byte_ok = scancode_valid_in & ~error_in;

    generate
        if (DECODE != 0) begin : g_decode
            kbd_state_t r_state;
            logic       w_is_prefix;

            assign w_is_prefix = (scancode_in == PS2_EXT) || (scancode_in == PS2_BRK);

            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    r_state <= IDLE;
                end else if (error_in) begin
                    r_state <= IDLE;
                end else if (scancode_valid_in) begin
                    case (r_state)
                        IDLE: begin
                            if (scancode_in == PS2_EXT)      r_state <= E0;
                            else if (scancode_in == PS2_BRK) r_state <= F0;
                            else                             r_state <= IDLE;
                        end
                        E0: begin
                            if (scancode_in == PS2_BRK)      r_state <= E0F0;
                            else if (scancode_in == PS2_EXT) r_state <= E0;
                            else                             r_state <= IDLE;
                        end
                        F0: begin
                            // E0 after F0 is accepted out of order
                            if (scancode_in == PS2_EXT)      r_state <= E0F0;
                            else if (scancode_in == PS2_BRK) r_state <= F0;
                            else                             r_state <= IDLE;
                        end
                        E0F0: begin
                            if (w_is_prefix) r_state <= E0F0;
                            else             r_state <= IDLE;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end

            // The state already encodes the brk/ext flags of the pending event
            always_comb begin
                w_emit       = 1'b0;
                w_event.brk  = 1'b0;
                w_event.ext  = 1'b0;
                w_event.code = scancode_in;
                if (w_byte_ok && !w_is_prefix) begin
                    w_emit      = 1'b1;
                    w_event.brk = (r_state == F0) || (r_state == E0F0);
                    w_event.ext = (r_state == E0) || (r_state == E0F0);
                end
            end
        end else begin : g_raw
            always_comb begin
                w_emit       = w_byte_ok;
                w_event.brk  = 1'b0;
                w_event.ext  = 1'b0;
                w_event.code = scancode_in;
            end
        end
    endgenerate

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .i_push  (w_emit),
        .i_pop   (pop_in),
        .i_wdata (w_event),
        .o_rdata (data_out),
        .o_count (count_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Dropped only when full and no accepted pop frees a slot this cycle
    assign w_drop = w_emit & w_full & ~(pop_in & ~w_empty);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow_in) begin
            r_overflow <= 1'b0;
        end
    end

    generate
        if (SNAP_BYTES > 1) begin : g_snap_wide
            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    r_snap <= '0;
                end else if (w_byte_ok) begin
                    r_snap <= {r_snap[8*SNAP_BYTES-9:0], scancode_in};
                end
            end
        end else begin : g_snap_byte
            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    r_snap <= '0;
                end else if (w_byte_ok) begin
                    r_snap <= scancode_in;
                end
            end
        end
    endgenerate

    assign valid_out    = ~w_empty;
    assign overflow_out = r_overflow;
    assign snapshot_out = r_snap;

endmodule
`default_nettype wire

// File: tb/tb_kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_event_fifo
// Description : Bench for kbd_event_fifo. Three instances share the byte
//               stream: decode DEPTH=16, decode DEPTH=4, raw DEPTH=16.
//               Expected events are queued as bytes are driven and compared
//               against the head after every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_event_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, valid, err, clr, pop_d, pop_s, pop_r;
    logic [7:0] code;

    logic [9:0]  data_d, data_s, data_r;
    logic        vld_d, vld_s, vld_r, ovf_d, ovf_s, ovf_r;
    logic [4:0]  cnt_d, cnt_r;
    logic [2:0]  cnt_s;
    logic [31:0] snap_d, snap_s, snap_r;

    kbd_event_fifo #(.DEPTH(16), .SNAP_BYTES(4), .DECODE(1)) u_dut_d (
        .clk_in(clk), .rst_in(rst_n), .scancode_in(code), .scancode_valid_in(valid),
        .error_in(err), .pop_in(pop_d), .clr_overflow_in(clr), .data_out(data_d),
        .valid_out(vld_d), .count_out(cnt_d), .overflow_out(ovf_d), .snapshot_out(snap_d));

    kbd_event_fifo #(.DEPTH(4), .SNAP_BYTES(4), .DECODE(1)) u_dut_s (
        .clk_in(clk), .rst_in(rst_n), .scancode_in(code), .scancode_valid_in(valid),
        .error_in(err), .pop_in(pop_s), .clr_overflow_in(clr), .data_out(data_s),
        .valid_out(vld_s), .count_out(cnt_s), .overflow_out(ovf_s), .snapshot_out(snap_s));

    kbd_event_fifo #(.DEPTH(16), .SNAP_BYTES(4), .DECODE(0)) u_dut_r (
        .clk_in(clk), .rst_in(rst_n), .scancode_in(code), .scancode_valid_in(valid),
        .error_in(err), .pop_in(pop_r), .clr_overflow_in(clr), .data_out(data_r),
        .valid_out(vld_r), .count_out(cnt_r), .overflow_out(ovf_r), .snapshot_out(snap_r));

    typedef struct {
        logic       v;
        logic       e;
        logic [7:0] b;
        logic       emit;   // decode-mode event expected
        logic [9:0] ev;
    } vec_t;

    vec_t        tbl [20];
    logic [9:0]  q_d[$], q_s[$], q_r[$];
    logic        m_ovf_d, m_ovf_s, m_ovf_r;
    logic [31:0] m_snap;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("d_count", 32'(cnt_d), 32'(q_d.size()));
        chk("d_valid", 32'(vld_d), 32'(q_d.size() != 0));
        chk("d_ovf",   32'(ovf_d), 32'(m_ovf_d));
        chk("d_snap",  snap_d, m_snap);
        if (q_d.size() != 0) chk("d_head", 32'(data_d), 32'(q_d[0]));
        chk("s_count", 32'(cnt_s), 32'(q_s.size()));
        chk("s_valid", 32'(vld_s), 32'(q_s.size() != 0));
        chk("s_ovf",   32'(ovf_s), 32'(m_ovf_s));
        chk("s_snap",  snap_s, m_snap);
        if (q_s.size() != 0) chk("s_head", 32'(data_s), 32'(q_s[0]));
        chk("r_count", 32'(cnt_r), 32'(q_r.size()));
        chk("r_valid", 32'(vld_r), 32'(q_r.size() != 0));
        chk("r_ovf",   32'(ovf_r), 32'(m_ovf_r));
        chk("r_snap",  snap_r, m_snap);
        if (q_r.size() != 0) chk("r_head", 32'(data_r), 32'(q_r[0]));
    endtask

    // One clock: update the scoreboard, drive, clock, then check everything
    task automatic step(input logic v, input logic e, input logic [7:0] b,
                        input logic emit, input logic [9:0] ev,
                        input logic pd, input logic ps, input logic pr, input logic c);
        logic ok;
        ok = v && !e;
        if (pd && q_d.size() != 0) void'(q_d.pop_front());
        if (ps && q_s.size() != 0) void'(q_s.pop_front());
        if (pr && q_r.size() != 0) void'(q_r.pop_front());
        if (c) begin
            m_ovf_d = 1'b0; m_ovf_s = 1'b0; m_ovf_r = 1'b0;
        end
        if (ok && emit) begin
            if (q_d.size() < 16) q_d.push_back(ev); else m_ovf_d = 1'b1;
            if (q_s.size() < 4)  q_s.push_back(ev); else m_ovf_s = 1'b1;
        end
        if (ok) begin
            if (q_r.size() < 16) q_r.push_back({2'b00, b}); else m_ovf_r = 1'b1;
            m_snap = {m_snap[23:0], b};
        end
        valid = v; err = e; code = b; pop_d = pd; pop_s = ps; pop_r = pr; clr = c;
        @(posedge clk);
        #1;
        valid = 1'b0; err = 1'b0; pop_d = 1'b0; pop_s = 1'b0; pop_r = 1'b0; clr = 1'b0;
        check_all();
    endtask

    // Reset asserted for one edge while other inputs are busy; reset must win
    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b1; code = 8'h1C; pop_d = 1'b1; pop_s = 1'b1; pop_r = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; valid = 1'b0; pop_d = 1'b0; pop_s = 1'b0; pop_r = 1'b0;
        q_d.delete(); q_s.delete(); q_r.delete();
        m_ovf_d = 1'b0; m_ovf_s = 1'b0; m_ovf_r = 1'b0; m_snap = '0;
        chk("d_rst_data", 32'(data_d), 32'h0);
        chk("s_rst_data", 32'(data_s), 32'h0);
        chk("r_rst_data", 32'(data_r), 32'h0);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; err = 1'b0; clr = 1'b0; code = 8'h00;
        pop_d = 1'b0; pop_s = 1'b0; pop_r = 1'b0;
        m_ovf_d = 1'b0; m_ovf_s = 1'b0; m_ovf_r = 1'b0; m_snap = '0;

        //             v     e     byte   emit  event
        tbl[0]  = '{1'b1, 1'b0, 8'h1C, 1'b1, 10'h01C};
        tbl[1]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 10'h000};
        tbl[2]  = '{1'b1, 1'b0, 8'h1C, 1'b1, 10'h21C};
        tbl[3]  = '{1'b1, 1'b0, 8'hE0, 1'b0, 10'h000};
        tbl[4]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 10'h000};
        tbl[5]  = '{1'b1, 1'b0, 8'h74, 1'b1, 10'h374};
        tbl[6]  = '{1'b1, 1'b0, 8'hE0, 1'b0, 10'h000};
        tbl[7]  = '{1'b1, 1'b0, 8'h75, 1'b1, 10'h175};
        tbl[8]  = '{1'b1, 1'b0, 8'h1C, 1'b1, 10'h01C};  // DEPTH=4 instance drops
        tbl[9]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 10'h000};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 10'h000};  // error cancels F0
        tbl[11] = '{1'b1, 1'b0, 8'h1C, 1'b1, 10'h01C};
        tbl[12] = '{1'b1, 1'b1, 8'h2A, 1'b0, 10'h000};  // error with byte
        tbl[13] = '{1'b1, 1'b0, 8'hF0, 1'b0, 10'h000};
        tbl[14] = '{1'b1, 1'b0, 8'hE0, 1'b0, 10'h000};  // F0 E0 order
        tbl[15] = '{1'b1, 1'b0, 8'h11, 1'b1, 10'h311};
        tbl[16] = '{1'b1, 1'b0, 8'hE0, 1'b0, 10'h000};
        tbl[17] = '{1'b1, 1'b0, 8'hE0, 1'b0, 10'h000};  // repeated E0
        tbl[18] = '{1'b1, 1'b0, 8'h14, 1'b1, 10'h114};
        tbl[19] = '{1'b1, 1'b0, 8'hE1, 1'b1, 10'h0E1};  // pause is a plain code

        do_reset();

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].emit, tbl[i].ev, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                chk("snap_after_1C_F0_1C", snap_d, 32'h001CF01C);
                chk("count_after_1C_F0_1C", 32'(cnt_d), 32'd2);
            end
        end

        // Overflow clear, then push+pop while full: count holds, no new overflow
        step(1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h2B, 1'b1, 10'h02B, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("s_full_pushpop_count", 32'(cnt_s), 32'd4);
        chk("s_full_pushpop_ovf", 32'(ovf_s), 32'd0);
        // Clear and drop in the same cycle: set wins
        step(1'b1, 1'b0, 8'h33, 1'b1, 10'h033, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("s_clr_vs_drop", 32'(ovf_s), 32'd1);

        // Drain everything; extra pops land on empty FIFOs
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk("d_drained_valid", 32'(vld_d), 32'd0);

        // Push and pop together on empty: push happens, pop ignored
        step(1'b1, 1'b0, 8'h1C, 1'b1, 10'h01C, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset mid-sequence after E0 with three entries queued
        step(1'b1, 1'b0, 8'h01, 1'b1, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b1, 10'h002, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b1, 10'h003, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hE0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'h75, 1'b1, 10'h075, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset_75", 32'(data_d), 32'h075);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_event_fifo.md
# kbd_event_fifo

Parametrised keyboard event buffer sitting between `ps2_rx` and the RISC-V core's memory-mapped peripheral space, in the 100 MHz core clock domain. Replaces the fixed 32-bit scancode shift register in `top_level`. Optionally assembles PS/2 set-2 prefix sequences (E0/F0) into single make/break events and queues them in a first-word-fall-through FIFO with overflow reporting. Also keeps a last-N-bytes snapshot for `seven_segment_controller`.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `SNAP_BYTES`, 4: raw bytes kept in the snapshot; 1..8.
- `DECODE`, 1: 1 = prefix-decoding mode, 0 = raw-byte mode.

Ports:
- `clk_in`  in  1  core clock.
- `rst_in`  in  1  synchronous reset, active-low.
- `scancode_in`  in  8  byte from `ps2_rx`.
- `scancode_valid_in`  in  1  one-cycle strobe qualifying `scancode_in`.
- `error_in`  in  1  `ps2_rx` frame error strobe.
- `pop_in`  in  1  consume head entry.
- `clr_overflow_in`  in  1  clear sticky overflow.
- `data_out`  out  10  head entry {break, extended, code[7:0]}; raw mode {2'b00, byte}.
- `valid_out`  out  1  FIFO non-empty.
- `count_out`  out  $clog2(DEPTH+1)  occupancy.
- `overflow_out`  out  1  sticky: an event was dropped.
- `snapshot_out`  out  8*SNAP_BYTES  last raw bytes, newest in [7:0].

## Operation

- Reset (`rst_in`=0 at edge): FIFO empty, `count_out`=0, `valid_out`=0, `data_out`=0, `overflow_out`=0, `snapshot_out`=0, decoder in IDLE. Reset wins over all other inputs.
- Snapshot: every `scancode_valid_in` shifts `{snapshot[8*SNAP_BYTES-9:0], scancode_in}`, prefixes included, in both modes.
- Raw mode (`DECODE`=0): each valid byte is one event.
- Decode mode: FSM states IDLE, E0, F0, E0F0. All transitions occur only on `scancode_valid_in`:
  - IDLE: 8'hE0 → E0; 8'hF0 → F0; any other byte → emit {0,0,byte}.
  - E0: 8'hF0 → E0F0; 8'hE0 → stay in E0; any other byte → emit {0,1,byte}, go to IDLE.
  - F0: 8'hE0 → E0F0 (tolerant); 8'hF0 → stay in F0; any other byte → emit {1,0,byte}, go to IDLE.
  - E0F0: 8'hE0/8'hF0 → stay in E0F0; any other byte → emit {1,1,byte}, go to IDLE.
  - 8'hE1 (pause) is an ordinary code byte.
- `error_in`: decoder returns to IDLE and no event is emitted. If `error_in` and `scancode_valid_in` coincide, error wins and the byte is discarded, including from the snapshot.
- Push: an emitted event is written if not full. If full and no pop this cycle, the event is dropped and `overflow_out` is set.
- Pop: `pop_in` while empty is ignored and has no side effects.
- Simultaneous push and pop:
  - Non-empty: both occur and count is unchanged, including when full, so no overflow.
  - Empty: the push occurs and the pop is ignored.
- Overflow: `clr_overflow_in` clears `overflow_out`. If a drop occurs in the same cycle, set wins.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `count_out`.

## Timing

- All outputs are registered; there is no combinational input→output path.
- Latency: the completing byte's strobe at edge N gives `valid_out`/`data_out`/`count_out` updated after edge N. `snapshot_out` updates at the same edge.
- FWFT: `data_out` always shows the head entry while `valid_out`=1. After a pop at edge N, the next entry (or `valid_out`=0) appears after edge N.
- `data_out` holds its last value when empty; do not rely on it in that state.
- Sustained throughput: one push and one pop per cycle.

## Structure

- Package `kbd_pkg`:
  - `kbd_state_t` enum (IDLE, E0, F0, E0F0).
  - `PS2_EXT` = 8'hE0, `PS2_BRK` = 8'hF0.
  - `kbd_event_t` packed struct {logic brk; logic ext; logic [7:0] code}.
- Sub-module `sync_fifo` (params WIDTH, DEPTH): FWFT, registered head, push/pop/count/full/empty. `kbd_event_fifo` holds the decoder FSM, overflow logic and snapshot.

## Test plan

- Reset, then bytes 8'h1C, 8'hF0, 8'h1C (DECODE=1) → two entries: 10'h01C then 10'h21C. `count_out`=2, snapshot=32'h001CF01C.
- Sequence E0 F0 74 → single entry 10'h374. E0 75 → 10'h175. Pop each → `valid_out` drops after the last pop.
- DEPTH=4: push 5 events with no pop → `count_out`=4, `overflow_out`=1, head still the first event. Then push+pop in the same cycle while full → count stays 4 and no new overflow.
- F0, then `error_in`, then 8'h1C → entry 10'h01C (prefix discarded). `error_in` coincident with a valid 8'h2A → nothing queued, snapshot unchanged.
- DECODE=0: bytes E0 F0 74 → three entries 10'h0E0, 10'h0F0, 10'h074. Pop on empty → no change.
- Drive `rst_in`=0 mid-sequence after E0 with 3 queued entries → all outputs 0 next cycle. A following 8'h75 → 10'h075.
